// File: rtl/ft_host_pkg.sv
// Shared types and constants for the FT245 host outgoing-path arbiter.
// No logic of its own; imported by the interface and the arbiter modules.
// Status codes decide how many beats a transfer occupies.
package ft_host_pkg;

  localparam int CNT_W = 28;

  localparam logic [7:0] STATUS_WRITE = 8'hFD;
  localparam logic [7:0] STATUS_PING  = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_BURST   = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  // A write ack carries data_count+1 beats; everything else is a single beat.
  function automatic logic is_write(input logic [31:0] status);
    return status[7:0] == STATUS_WRITE;
  endfunction

endpackage

// File: rtl/ft_host_out_arbiter_if.sv
// Bundle of requester-side and output-handler-side signals of the arbiter.
// Purely wiring, no latency.
// Backpressure is carried by oh_ready / req_ready.
interface ft_host_out_arbiter_if
  import ft_host_pkg::*;
#(
  parameter int NUM_REQ = 2
);

  logic [NUM_REQ-1:0]       req_pending;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       req_en;
  logic [32*NUM_REQ-1:0]    req_status;
  logic [32*NUM_REQ-1:0]    req_address;
  logic [CNT_W*NUM_REQ-1:0] req_data_count;
  logic [32*NUM_REQ-1:0]    req_data;

  logic                     oh_ready;
  logic                     oh_en;
  logic [31:0]              out_status;
  logic [31:0]              out_address;
  logic [CNT_W-1:0]         out_data_count;
  logic [31:0]              out_data;

  logic [NUM_REQ-1:0]       grant;
  logic                     timeout_err;

  // Arbiter side.
  modport slave (
    input  req_pending, req_en, req_status, req_address, req_data_count, req_data, oh_ready,
    output req_ready, oh_en, out_status, out_address, out_data_count, out_data, grant, timeout_err
  );

  // Requesters / output handler side.
  modport master (
    output req_pending, req_en, req_status, req_address, req_data_count, req_data, oh_ready,
    input  req_ready, oh_en, out_status, out_address, out_data_count, out_data, grant, timeout_err
  );

endinterface

// File: rtl/ft_host_out_arbiter_rr_pick.sv
// Round-robin first-set finder: first request at or after last+1 (mod NUM_REQ).
// Purely combinational.
// No backpressure; result is sampled by the arbiter in IDLE.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] gnt
);

  logic [IDX_W-1:0] idx;
  logic             found;

  // Walk the requesters starting just after the previous owner.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDX_W'((int'(last) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ft_host_out_arbiter.sv
// Shares the host output path among NUM_REQ requesters, round-robin per transfer.
// Grant one cycle after req_pending; beats/data pass through with zero latency.
// req_ready mirrors oh_ready for the owner only; no buffering, watchdog frees stalled owners.
module ft_host_out_arbiter
  import ft_host_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 1024
) (
  input logic                  clk,
  input logic                  rst,
  ft_host_out_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic [31:0]        wd_q, wd_d;
  logic               timeout_err_q, timeout_err_d;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   owner_idx;
  logic [31:0]        mux_status, mux_address, mux_data;
  logic [CNT_W-1:0]   mux_count;
  logic               beat_ok;
  logic               wd_fire;
  logic               release_now;
  logic [CNT_W-1:0]   first_rem;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req  (bus.req_pending),
    .last (last_q),
    .gnt  (pick_grant)
  );

  // Select the owner's fields from the registered one-hot grant; zero when unowned.
  always_comb begin
    owner_idx   = '0;
    mux_status  = '0;
    mux_address = '0;
    mux_data    = '0;
    mux_count   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        owner_idx   = IDX_W'(i);
        mux_status  = bus.req_status[32*i +: 32];
        mux_address = bus.req_address[32*i +: 32];
        mux_data    = bus.req_data[32*i +: 32];
        mux_count   = bus.req_data_count[CNT_W*i +: CNT_W];
      end
    end
  end

  // A beat only counts when the owner strobes while the handler is ready.
  assign beat_ok = (|(bus.req_en & grant_q)) & bus.oh_ready;
  assign wd_fire = (TIMEOUT != 0) && (wd_q == 32'(TIMEOUT - 1));
  // All-ones count would wrap data_count+1 to zero; it is treated as a single beat.
  assign first_rem = (is_write(mux_status) && (mux_count != '1)) ? mux_count : '0;

  // Next-state logic: arbitration, beat counting and watchdog.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    remaining_d   = remaining_q;
    wd_d          = wd_q;
    timeout_err_d = 1'b0;
    release_now   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|bus.req_pending) begin
          grant_d = pick_grant;
          wd_d    = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT, ST_BURST: begin
        if (beat_ok) begin
          wd_d = '0;
          if (state_q == ST_GRANT) begin
            remaining_d = first_rem;
            if (first_rem != '0) state_d = ST_BURST;
            else                 release_now = 1'b1;
          end else begin
            remaining_d = remaining_q - 1'b1;
            if (remaining_q == CNT_W'(1)) release_now = 1'b1;
          end
        end else if (wd_fire) begin
          timeout_err_d = 1'b1;
          release_now   = 1'b1;
        end else if (TIMEOUT != 0) begin
          wd_d = wd_q + 32'd1;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Dropping grant on the way into RELEASE keeps stray strobes off oh_en.
    if (release_now) begin
      state_d = ST_RELEASE;
      grant_d = '0;
      last_d  = owner_idx;
    end
  end

  // State registers with synchronous reset; last starts at NUM_REQ-1 so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      last_q        <= IDX_W'(NUM_REQ - 1);
      remaining_q   <= '0;
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_q        <= last_d;
      remaining_q   <= remaining_d;
      wd_q          <= wd_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.req_ready      = {NUM_REQ{bus.oh_ready}} & grant_q;
  assign bus.oh_en          = |(bus.req_en & grant_q);
  assign bus.out_status     = mux_status;
  assign bus.out_address    = mux_address;
  assign bus.out_data       = mux_data;
  assign bus.out_data_count = mux_count;
  assign bus.grant          = grant_q;
  assign bus.timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_ft_host_out_arbiter.sv
// Directed bench for ft_host_out_arbiter with two requesters and TIMEOUT=16.
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
// Handler is normally ready; explicit gaps exercise grant hold.
module tb_ft_host_out_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  ft_host_out_arbiter_if #(.NUM_REQ(2)) if_i ();

  ft_host_out_arbiter #(
    .NUM_REQ (2),
    .TIMEOUT (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (if_i.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] st, input logic [27:0] cnt, input logic [31:0] dat);
    if_i.req_status[32*i +: 32]     = {24'h0, st};
    if_i.req_address[32*i +: 32]    = 32'hA000_0000 + 32'(i);
    if_i.req_data_count[28*i +: 28] = cnt;
    if_i.req_data[32*i +: 32]       = dat;
  endtask

  initial begin
    logic [1:0] exp_g;
    checks   = 0;
    failures = 0;
    clk      = 1'b0;
    rst      = 1'b1;
    if_i.req_pending    = '0;
    if_i.req_en         = '0;
    if_i.req_status     = '0;
    if_i.req_address    = '0;
    if_i.req_data_count = '0;
    if_i.req_data       = '0;
    if_i.oh_ready       = 1'b1;

    // Reset values.
    tick();
    tick();
    chk("reset_grant", 32'(if_i.grant), 32'h0);
    chk("reset_req_ready", 32'(if_i.req_ready), 32'h0);
    chk("reset_oh_en", 32'(if_i.oh_en), 32'h0);
    chk("reset_out_status", if_i.out_status, 32'h0);
    chk("reset_out_data", if_i.out_data, 32'h0);
    chk("reset_out_count", 32'(if_i.out_data_count), 32'h0);
    chk("reset_timeout_err", 32'(if_i.timeout_err), 32'h0);
    rst = 1'b0;

    // Single ping from requester 0.
    set_req(0, 8'hFF, 28'h0, 32'hD000_0000);
    if_i.req_pending = 2'b01;
    #1;
    chk("ping_grant_before", 32'(if_i.grant), 32'h0);
    tick();
    chk("ping_grant", 32'(if_i.grant), 32'h1);
    chk("ping_req_ready", 32'(if_i.req_ready), 32'h1);
    chk("ping_out_status", if_i.out_status, 32'hFF);
    chk("ping_out_address", if_i.out_address, 32'hA000_0000);
    if_i.req_en = 2'b01;
    #1;
    chk("ping_oh_en", 32'(if_i.oh_en), 32'h1);
    chk("ping_out_data", if_i.out_data, 32'hD000_0000);
    tick();
    if_i.req_en      = 2'b00;
    if_i.req_pending = 2'b00;
    #1;
    chk("ping_grant_release", 32'(if_i.grant), 32'h0);
    chk("ping_oh_en_release", 32'(if_i.oh_en), 32'h0);
    tick();
    chk("ping_grant_idle", 32'(if_i.grant), 32'h0);

    // Four-beat write from requester 1 with handler-ready gaps.
    set_req(1, 8'hFD, 28'd3, 32'h100);
    if_i.req_pending = 2'b10;
    tick();
    if_i.req_pending = 2'b00;
    chk("wr_grant", 32'(if_i.grant), 32'h2);
    chk("wr_out_count", 32'(if_i.out_data_count), 32'd3);
    for (int b = 0; b < 4; b++) begin
      if_i.req_data[63:32] = 32'h100 + 32'(b);
      if_i.req_en = 2'b10;
      #1;
      chk("wr_oh_en", 32'(if_i.oh_en), 32'h1);
      chk("wr_out_data", if_i.out_data, 32'h100 + 32'(b));
      tick();
      if_i.req_en = 2'b00;
      if (b < 3) begin
        chk("wr_grant_held", 32'(if_i.grant), 32'h2);
        if_i.oh_ready = 1'b0;
        #1;
        chk("wr_ready_gap", 32'(if_i.req_ready), 32'h0);
        tick();
        if_i.oh_ready = 1'b1;
      end
    end
    #1;
    chk("wr_grant_release", 32'(if_i.grant), 32'h0);
    tick();

    // Contention: grants alternate, loser strobes never reach oh_en.
    set_req(0, 8'hFF, 28'h0, 32'h11);
    set_req(1, 8'hFF, 28'h0, 32'h22);
    if_i.req_pending = 2'b11;
    for (int r = 0; r < 4; r++) begin
      exp_g = (r % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      chk("cont_grant", 32'(if_i.grant), 32'(exp_g));
      if_i.req_en = ~exp_g;
      #1;
      chk("cont_loser_oh_en", 32'(if_i.oh_en), 32'h0);
      if_i.req_en = 2'b11;
      #1;
      chk("cont_owner_oh_en", 32'(if_i.oh_en), 32'h1);
      tick();
      if_i.req_en = 2'b00;
      chk("cont_release", 32'(if_i.grant), 32'h0);
      tick();
      chk("cont_idle", 32'(if_i.grant), 32'h0);
    end
    if_i.req_pending = 2'b00;

    // Three-beat write from requester 0; stray strobes must not be counted.
    set_req(0, 8'hFD, 28'd2, 32'h200);
    if_i.req_pending = 2'b01;
    tick();
    if_i.req_pending = 2'b00;
    chk("ns_grant", 32'(if_i.grant), 32'h1);
    if_i.req_en = 2'b01;
    tick();
    if_i.req_en = 2'b10;
    #1;
    chk("ns_nonowner_oh_en", 32'(if_i.oh_en), 32'h0);
    tick();
    if_i.req_en   = 2'b01;
    if_i.oh_ready = 1'b0;
    tick();
    if_i.oh_ready = 1'b1;
    if_i.req_en   = 2'b01;
    tick();
    if_i.req_en = 2'b00;
    #1;
    chk("ns_grant_after_beat2", 32'(if_i.grant), 32'h1);
    if_i.req_en = 2'b01;
    tick();
    if_i.req_en = 2'b00;
    #1;
    chk("ns_grant_after_beat3", 32'(if_i.grant), 32'h0);
    tick();

    // All-ones data count is a single beat.
    set_req(1, 8'hFD, 28'hFFF_FFFF, 32'h300);
    if_i.req_pending = 2'b10;
    tick();
    if_i.req_pending = 2'b00;
    chk("wrap_grant", 32'(if_i.grant), 32'h2);
    if_i.req_en = 2'b10;
    tick();
    if_i.req_en = 2'b00;
    #1;
    chk("wrap_release", 32'(if_i.grant), 32'h0);
    tick();

    // Watchdog: requester 0 stalls, released after 16 cycles, then requester 1.
    if_i.req_pending = 2'b11;
    tick();
    chk("wd_grant", 32'(if_i.grant), 32'h1);
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk("wd_no_err", 32'(if_i.timeout_err), 32'h0);
      chk("wd_held", 32'(if_i.grant), 32'h1);
    end
    tick();
    chk("wd_err_pulse", 32'(if_i.timeout_err), 32'h1);
    chk("wd_release", 32'(if_i.grant), 32'h0);
    tick();
    chk("wd_err_cleared", 32'(if_i.timeout_err), 32'h0);
    tick();
    chk("wd_next_grant", 32'(if_i.grant), 32'h2);
    if_i.req_pending = 2'b00;
    if_i.req_en = 2'b10;
    tick();
    if_i.req_en = 2'b00;
    tick();

    // Reset mid-burst; round-robin pointer must return to its reset value.
    set_req(0, 8'hFF, 28'h0, 32'h44);
    if_i.req_pending = 2'b01;
    tick();
    if_i.req_pending = 2'b00;
    chk("rst_pre_grant", 32'(if_i.grant), 32'h1);
    if_i.req_en = 2'b01;
    tick();
    if_i.req_en = 2'b00;
    tick();
    set_req(1, 8'hFD, 28'd4, 32'h400);
    if_i.req_pending = 2'b10;
    tick();
    chk("rst_burst_grant", 32'(if_i.grant), 32'h2);
    if_i.req_en = 2'b10;
    tick();
    tick();
    if_i.req_en = 2'b00;
    rst = 1'b1;
    tick();
    chk("rst_grant", 32'(if_i.grant), 32'h0);
    chk("rst_req_ready", 32'(if_i.req_ready), 32'h0);
    chk("rst_out_data", if_i.out_data, 32'h0);
    rst = 1'b0;
    if_i.req_pending = 2'b11;
    tick();
    chk("rst_first_winner", 32'(if_i.grant), 32'h1);
    if_i.req_pending = 2'b00;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
